// File: rtl/aes_job_sched.sv
// Round-robin job controller in front of a fixed-latency AES-128 core: accepts one
// request at a time, holds it on the core for AES_LATENCY cycles, returns the tagged ciphertext.
module aes_job_sched #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned AES_LATENCY = 11,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*128-1:0]   req_key_i,
  input  logic [NUM_REQ*128-1:0]   req_data_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [127:0]             rsp_data_o,
  output logic [1:0]               rsp_id_o,
  output logic                     core_en_o,
  output logic [127:0]             core_key_o,
  output logic [127:0]             core_data_o,
  input  logic [127:0]             core_result_i,
  output logic                     busy_o,
  output logic [CNT_W-1:0]         jobs_done_o
);

  localparam int unsigned ID_W   = 2;
  localparam int unsigned DIST_W = ID_W + 1;
  localparam int unsigned LAT_W  = $clog2(AES_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAST_CNT = LAT_W'(AES_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ID_W-1:0]    r_last_grant;
  logic [ID_W-1:0]    r_id;
  logic [LAT_W-1:0]   r_cnt;
  logic [127:0]       r_core_key;
  logic [127:0]       r_core_data;
  logic [127:0]       r_rsp_data;
  logic [ID_W-1:0]    r_rsp_id;
  logic               r_core_en;
  logic               r_rsp_valid;
  logic               r_busy;
  logic [CNT_W-1:0]   r_jobs_done;

  logic               w_any;
  logic [ID_W-1:0]    w_grant;
  logic [DIST_W-1:0]  w_dist;
  logic [DIST_W-1:0]  w_best_d;
  logic [127:0]       w_key;
  logic [127:0]       w_data;
  logic               w_accept;
  logic               w_capture;
  logic               w_rsp_hs;

  // Round-robin: pick the valid requester closest after the last grant.
  always_comb begin
    w_any    = 1'b0;
    w_grant  = '0;
    w_dist   = '0;
    w_best_d = DIST_W'(NUM_REQ);
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = DIST_W'((i + 2 * NUM_REQ - 1 - int'(r_last_grant)) % NUM_REQ);
      if (req_valid_i[i] && (w_dist < w_best_d)) begin
        w_best_d = w_dist;
        w_grant  = ID_W'(i);
        w_any    = 1'b1;
      end
    end
  end

  always_comb begin
    w_key  = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == ID_W'(i)) begin
        w_key  = req_key_i[128*i +: 128];
        w_data = req_data_i[128*i +: 128];
      end
    end
  end

  // Next state and handshake strobes; ready is combinational and masked while in reset.
  always_comb begin
    w_state_nxt = r_state;
    req_ready_o = '0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_rsp_hs    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any && rst_n) begin
          req_ready_o = NUM_REQ'(1) << w_grant;
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (rsp_ready_i) begin
          w_rsp_hs    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_id         <= '0;
      r_cnt        <= '0;
      r_core_key   <= '0;
      r_core_data  <= '0;
      r_rsp_data   <= '0;
      r_rsp_id     <= '0;
      r_core_en    <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_jobs_done  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_core_en   <= (w_state_nxt == RUN);
      r_rsp_valid <= (w_state_nxt == HOLD);
      r_busy      <= (w_state_nxt != IDLE);
      if (w_accept) begin
        r_core_key   <= w_key;
        r_core_data  <= w_data;
        r_id         <= w_grant;
        r_last_grant <= w_grant;
        r_cnt        <= '0;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt + LAT_W'(1);
      end
      if (w_capture) begin
        r_rsp_data <= core_result_i;
        r_rsp_id   <= r_id;
      end
      if (w_rsp_hs) begin
        r_jobs_done <= r_jobs_done + CNT_W'(1);
      end
    end
  end

  assign core_en_o   = r_core_en;
  assign core_key_o  = r_core_key;
  assign core_data_o = r_core_data;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_id_o    = r_rsp_id;
  assign busy_o      = r_busy;
  assign jobs_done_o = r_jobs_done;

endmodule

// File: tb/tb_aes_job_sched.sv
// Directed bench for aes_job_sched: behavioural AES core on the default instance,
// a CNT_W=4 instance with an XOR core for counter wrap and back-to-back period.
module tb_aes_job_sched;

  localparam int LAT = 11;

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_FIPS = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_FIPS = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] D0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1 = 128'hfedcba9876543210a5a5a5a55a5a5a5a;
  localparam logic [127:0] D1 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [255:0] req_key, req_data;
  logic         rsp_valid, rsp_ready;
  logic [127:0] rsp_data;
  logic [1:0]   rsp_id;
  logic         core_en;
  logic [127:0] core_key, core_data, core_res;
  logic         busy;
  logic [15:0]  jobs_done;

  logic [1:0]   v4_valid;
  logic [1:0]   v4_ready;
  logic [255:0] v4_key, v4_data;
  logic         v4_rsp_valid, v4_rsp_ready;
  logic [127:0] v4_rsp_data;
  logic [1:0]   v4_rsp_id;
  logic         v4_core_en;
  logic [127:0] v4_core_key, v4_core_data, v4_core_res;
  logic         v4_busy;
  logic [3:0]   v4_jobs_done;

  aes_job_sched #(.NUM_REQ(2), .AES_LATENCY(LAT), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_key_i(req_key), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_id_o(rsp_id),
    .core_en_o(core_en), .core_key_o(core_key), .core_data_o(core_data),
    .core_result_i(core_res), .busy_o(busy), .jobs_done_o(jobs_done)
  );

  aes_job_sched #(.NUM_REQ(2), .AES_LATENCY(LAT), .CNT_W(4)) u_w4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(v4_valid), .req_ready_o(v4_ready),
    .req_key_i(v4_key), .req_data_i(v4_data),
    .rsp_valid_o(v4_rsp_valid), .rsp_ready_i(v4_rsp_ready),
    .rsp_data_o(v4_rsp_data), .rsp_id_o(v4_rsp_id),
    .core_en_o(v4_core_en), .core_key_o(v4_core_key), .core_data_o(v4_core_data),
    .core_result_i(v4_core_res), .busy_o(v4_busy), .jobs_done_o(v4_jobs_done)
  );

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] brev(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] st [16];
    logic [7:0] ns [16];
    logic [7:0] rk [16];
    logic [7:0] t0, t1, t2, t3, a0, a1, a2, a3, rcon;
    logic [127:0] r;
    rcon = 8'h01;
    for (int i = 0; i < 16; i++) begin
      rk[i] = key[8*i +: 8];
      st[i] = pt[8*i +: 8] ^ rk[i];
    end
    for (int rnd = 1; rnd <= 10; rnd++) begin
      t0 = sbox_t[rk[13]]; t1 = sbox_t[rk[14]]; t2 = sbox_t[rk[15]]; t3 = sbox_t[rk[12]];
      rk[0] = rk[0] ^ t0 ^ rcon; rk[1] = rk[1] ^ t1; rk[2] = rk[2] ^ t2; rk[3] = rk[3] ^ t3;
      for (int i = 4; i < 16; i++) rk[i] = rk[i] ^ rk[i-4];
      rcon = xt(rcon);
      for (int i = 0; i < 16; i++) st[i] = sbox_t[st[i]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) ns[rw + 4*c] = st[rw + 4*((c + rw) % 4)];
      for (int c = 0; c < 4; c++) begin
        a0 = ns[4*c]; a1 = ns[4*c+1]; a2 = ns[4*c+2]; a3 = ns[4*c+3];
        if (rnd < 10) begin
          ns[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          ns[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          ns[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          ns[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) st[i] = ns[i] ^ rk[i];
    end
    for (int i = 0; i < 16; i++) r[8*i +: 8] = st[i];
    return r;
  endfunction

  // Behavioural core: result only valid in the LAT-th consecutive enabled cycle.
  int           en_run;
  logic [127:0] aes_res;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_run  <= 0;
      aes_res <= '0;
    end else if (core_en) begin
      en_run <= en_run + 1;
      if (en_run == 0) aes_res <= aes_enc(core_key, core_data);
    end else begin
      en_run <= 0;
    end
  end
  assign core_res    = (core_en && en_run >= LAT - 1) ? aes_res : {4{32'hdeadbeef}};
  assign v4_core_res = v4_core_en ? (v4_core_key ^ v4_core_data) : '0;

  // ---------------- monitors ----------------
  int           acc_t[$], acc_id[$], rv_t[$], hs_t[$], hs_id[$], en_len[$];
  logic [127:0] hs_data[$];
  int           en_cur;
  logic         prev_rv;
  int           a4_t[$], h4_id[$], jd4[$];
  logic         hs4_prev;

  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      en_cur = 0; prev_rv = 1'b0; hs4_prev = 1'b0;
    end else begin
      if (req_ready[1]) begin acc_t.push_back(cyc); acc_id.push_back(1); end
      else if (req_ready[0]) begin acc_t.push_back(cyc); acc_id.push_back(0); end
      if (rsp_valid && !prev_rv) rv_t.push_back(cyc);
      prev_rv = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        hs_t.push_back(cyc); hs_id.push_back(int'(rsp_id)); hs_data.push_back(rsp_data);
      end
      if (core_en) en_cur++;
      else if (en_cur != 0) begin en_len.push_back(en_cur); en_cur = 0; end
      if (hs4_prev) jd4.push_back(int'(v4_jobs_done));
      hs4_prev = v4_rsp_valid && v4_rsp_ready;
      if (|v4_ready) a4_t.push_back(cyc);
      if (v4_rsp_valid && v4_rsp_ready) h4_id.push_back(int'(v4_rsp_id));
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clr_q();
    acc_t.delete(); acc_id.delete(); rv_t.delete(); hs_t.delete();
    hs_id.delete(); hs_data.delete(); en_len.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    clr_q();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit, expected run completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int t_acc;
    logic [127:0] cap;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h01;
      if (x == 0) inv = 8'h00;
      else for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    req_valid = 2'b00; req_key = '0; req_data = '0; rsp_ready = 1'b0;
    v4_valid = 2'b00; v4_key = '0; v4_data = '0; v4_rsp_ready = 1'b1;

    // Reset state, with a valid request present during reset
    #1 req_valid = 2'b01;
    #1;
    chk("rst_ready", 128'(req_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_core_en", 128'(core_en), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_core_key", core_key, 128'(0));
    chk("rst_rsp_data", rsp_data, 128'(0));
    chk("rst_jobs", 128'(jobs_done), 128'(0));
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle with no requests
    bad = 0;
    repeat (50) begin
      @(negedge clk); #1;
      if (req_ready != 2'b00 || busy || core_en || rsp_valid) bad++;
    end
    chk("idle_quiet", 128'(bad), 128'(0));

    // FIPS-197 App. B on requester 0
    @(negedge clk);
    req_key[127:0] = brev(K_FIPS); req_data[127:0] = brev(P_FIPS);
    rsp_ready = 1'b1; req_valid = 2'b01;
    for (int i = 0; i < 50 && acc_t.size() == 0; i++) @(negedge clk);
    req_valid = 2'b00;
    for (int i = 0; i < 100 && hs_id.size() == 0; i++) @(negedge clk);
    chk("t1_rsp_count", 128'(hs_id.size()), 128'(1));
    if (hs_id.size() > 0 && rv_t.size() > 0 && en_len.size() > 0 && acc_t.size() > 0) begin
      chk("t1_cipher", hs_data[0], brev(C_FIPS));
      chk("t1_id", 128'(hs_id[0]), 128'(0));
      chk("t1_latency", 128'(rv_t[0] - acc_t[0]), 128'(12));
      chk("t1_en_len", 128'(en_len[0]), 128'(11));
    end
    @(negedge clk); #1;
    chk("t1_key_hold", core_key, brev(K_FIPS));
    chk("t1_rsp_hold", rsp_data, brev(C_FIPS));
    chk("t1_jobs", 128'(jobs_done), 128'(1));

    // Both requesters continuously valid, six jobs
    do_reset();
    req_key = {K1, K0}; req_data = {D1, D0}; rsp_ready = 1'b1; req_valid = 2'b11;
    for (int i = 0; i < 200 && acc_t.size() < 6; i++) @(negedge clk);
    req_valid = 2'b00;
    for (int i = 0; i < 100 && hs_id.size() < 6; i++) @(negedge clk);
    chk("t2_accepts", 128'(acc_t.size()), 128'(6));
    chk("t2_rsps", 128'(hs_id.size()), 128'(6));
    for (int k = 0; k < 6; k++) begin
      if (k < acc_t.size()) begin
        chk($sformatf("t2_grant%0d", k), 128'(acc_id[k]), 128'(k % 2));
        if (k > 0) chk($sformatf("t2_period%0d", k), 128'(acc_t[k] - acc_t[k-1]), 128'(13));
      end
      if (k < hs_id.size()) begin
        chk($sformatf("t2_id%0d", k), 128'(hs_id[k]), 128'(k % 2));
        chk($sformatf("t2_data%0d", k), hs_data[k],
            (k % 2 == 0) ? aes_enc(K0, D0) : aes_enc(K1, D1));
      end
    end
    @(negedge clk); #1;
    chk("t2_jobs", 128'(jobs_done), 128'(6));

    // Back-pressure in HOLD with requester 1 waiting
    do_reset();
    rsp_ready = 1'b0; req_valid = 2'b01;
    for (int i = 0; i < 50 && acc_t.size() == 0; i++) @(negedge clk);
    req_valid = 2'b10;
    for (int i = 0; i < 50 && rv_t.size() == 0; i++) @(negedge clk);
    #1 cap = rsp_data;
    chk("t3_cap_data", cap, aes_enc(K0, D0));
    bad = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (!rsp_valid || rsp_data !== cap || req_ready != 2'b00 || core_en) bad++;
    end
    chk("t3_hold_stable", 128'(bad), 128'(0));
    @(negedge clk);
    rsp_ready = 1'b1;
    for (int i = 0; i < 50 && acc_t.size() < 2; i++) @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("t3_rsp_hold_after_hs", rsp_data, cap);
    if (acc_t.size() >= 2 && hs_t.size() >= 1) begin
      chk("t3_accept_after_hs", 128'(acc_t[1] - hs_t[0]), 128'(1));
      chk("t3_grant", 128'(acc_id[1]), 128'(1));
    end else chk("t3_accept_seen", 128'(acc_t.size()), 128'(2));
    for (int i = 0; i < 50 && hs_id.size() < 2; i++) @(negedge clk);
    if (hs_id.size() >= 2) begin
      chk("t3_id2", 128'(hs_id[1]), 128'(1));
      chk("t3_data2", hs_data[1], aes_enc(K1, D1));
    end else chk("t3_rsp2_seen", 128'(hs_id.size()), 128'(2));

    // Reset mid-RUN at cnt=5 of a requester-1 job
    do_reset();
    rsp_ready = 1'b1; req_valid = 2'b10;
    for (int i = 0; i < 50 && acc_t.size() == 0; i++) @(negedge clk);
    req_valid = 2'b00;
    t_acc = (acc_t.size() > 0) ? acc_t[0] : 0;
    for (int i = 0; i < 50 && cyc < t_acc + 6; i++) @(negedge clk);
    #1;
    chk("t4_mid_run_en", 128'(core_en), 128'(1));
    rst_n = 1'b0; req_valid = 2'b11;
    #1;
    chk("t4_rst_en", 128'(core_en), 128'(0));
    chk("t4_rst_busy", 128'(busy), 128'(0));
    chk("t4_rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("t4_rst_ready", 128'(req_ready), 128'(0));
    chk("t4_rst_key", core_key, 128'(0));
    chk("t4_rst_data", core_data, 128'(0));
    chk("t4_rst_id", 128'(rsp_id), 128'(0));
    chk("t4_rst_rv_seen", 128'(rv_t.size()), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    clr_q();
    for (int i = 0; i < 100 && acc_t.size() < 2; i++) @(negedge clk);
    req_valid = 2'b00;
    for (int i = 0; i < 100 && hs_id.size() < 2; i++) @(negedge clk);
    if (acc_id.size() >= 1) chk("t4_first_grant", 128'(acc_id[0]), 128'(0));
    chk("t4_rsp_count", 128'(hs_id.size()), 128'(2));
    if (hs_id.size() >= 2) begin
      chk("t4_id0", 128'(hs_id[0]), 128'(0));
      chk("t4_data0", hs_data[0], aes_enc(K0, D0));
      chk("t4_id1", 128'(hs_id[1]), 128'(1));
    end

    // CNT_W=4 instance: 17 back-to-back jobs from requester 1
    @(negedge clk);
    a4_t.delete(); h4_id.delete(); jd4.delete();
    v4_key = {K1, K0}; v4_data = {D1, D0}; v4_rsp_ready = 1'b1; v4_valid = 2'b10;
    for (int i = 0; i < 400 && a4_t.size() < 17; i++) @(negedge clk);
    v4_valid = 2'b00;
    for (int i = 0; i < 100 && jd4.size() < 17; i++) @(negedge clk);
    chk("t5_jobs_seen", 128'(jd4.size()), 128'(17));
    for (int k = 0; k < 17; k++) begin
      if (k < jd4.size()) chk($sformatf("t5_cnt%0d", k), 128'(jd4[k]), 128'((k + 1) % 16));
      if (k < h4_id.size()) chk($sformatf("t5_id%0d", k), 128'(h4_id[k]), 128'(1));
      if (k > 0 && k < a4_t.size())
        chk($sformatf("t5_period%0d", k), 128'(a4_t[k] - a4_t[k-1]), 128'(13));
    end
    chk("t5_data", v4_rsp_data, K1 ^ D1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/aes_job_sched.md
# aes_job_sched

Job controller in front of the 128-bit AES core. It arbitrates encryption requests from NUM_REQ requesters round-robin and runs one job at a time. For each job it holds the key and plaintext stable on the core with enable asserted for a fixed latency, then captures the ciphertext and returns it on a valid/ready response channel tagged with the requester ID. Sits between the requester fabric and the AES core's CipherKey_i/Data_i/en/AES_o ports.

## Interface
- NUM_REQ, 2, number of requesters; legal range 2..4.
- AES_LATENCY, 11, cycles from core enable with stable inputs to valid AES_o; must be ≥1.
- CNT_W, 16, width of the completed-job counter.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester job valid.
- req_ready_o  out  NUM_REQ  per-requester accept; at most one bit high.
- req_key_i  in  NUM_REQ*128  key for requester i at [128*i+127:128*i].
- req_data_i  in  NUM_REQ*128  plaintext for requester i, same slicing.
- rsp_valid_o  out  1  ciphertext available.
- rsp_ready_i  in  1  response consumer ready.
- rsp_data_o  out  128  ciphertext.
- rsp_id_o  out  2  requester index of this response.
- core_en_o  out  1  to AES en.
- core_key_o  out  128  to AES CipherKey_i.
- core_data_o  out  128  to AES Data_i.
- core_result_i  in  128  from AES AES_o.
- busy_o  out  1  high in RUN or HOLD.
- jobs_done_o  out  CNT_W  completed responses, wraps.

## Operation
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - Winner g = first i with req_valid_i[i], searching from last_grant+1 modulo NUM_REQ.
  - req_ready_o = onehot(g), combinational; all zero if no valid.
  - On handshake: latch req_key_i/req_data_i slice g into core_key_o/core_data_o, latch g into the ID register, last_grant←g, cnt←0, go RUN.
- RUN:
  - core_en_o=1; core inputs held constant; cnt increments each cycle.
  - At cnt==AES_LATENCY-1: rsp_data_o←core_result_i, rsp_id_o←ID, go HOLD.
- HOLD:
  - rsp_valid_o=1. On rsp_ready_i: jobs_done_o+1 (modulo 2^CNT_W), go IDLE.
  - No new acceptance in the handshake cycle.
- req_ready_o is all zero in RUN and HOLD. Requesters keep valid and payload stable until ready; the controller does not check this.
- core_key_o/core_data_o hold their last value in IDLE/HOLD; only core_en_o drops.
- rsp_data_o/rsp_id_o hold after the response handshake until the next capture.
- Payload is passed through bit-exact; no byte reordering.

## Timing
- Reset (async, immediate): state IDLE; core_en_o, rsp_valid_o, busy_o=0; req_ready_o=0 until rst_n high; core_key_o, core_data_o, rsp_data_o, rsp_id_o, jobs_done_o, cnt=0; last_grant=NUM_REQ-1, so requester 0 wins first.
- Reset mid-RUN or mid-HOLD discards the job; no response is produced.
- Accept at cycle T. core_en_o high T+1..T+AES_LATENCY. rsp_valid_o rises at T+AES_LATENCY+1.
- With rsp_ready_i=1, the minimum job period is AES_LATENCY+2 cycles (13 at default).
- rsp_ready_i low: HOLD indefinitely, rsp_data_o stable, core_en_o low, no requests accepted.
- Simultaneous valids: exactly one grant per IDLE cycle. A requester that keeps valid high is granted again only after every other valid requester has been served.
- Requests arriving during RUN/HOLD wait; nothing is dropped or queued internally.

## Test plan
- FIPS-197 App. B vector on requester 0 (core byte order, byte 0 in [7:0]): key bytes 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734, behavioural AES model as core. Required: ciphertext bytes 3925841d02dc09fbdc118597196a0b32, rsp_id_o=0, rsp_valid_o at accept+12 cycles, core_en_o high exactly 11 cycles.
- Both requesters valid continuously, rsp_ready_i=1, 6 jobs: grants 0,1,0,1,0,1; rsp_id_o matches each grant; accepts every 13 cycles; jobs_done_o=6.
- rsp_ready_i held low 20 cycles after rsp_valid_o rises, with requester 1 valid: rsp_valid_o and rsp_data_o stable, req_ready_o=0, core_en_o=0. Releasing rsp_ready_i causes requester 1 to be accepted the cycle after the handshake.
- rst_n pulsed low at cnt=5 of a requester-1 job: all outputs 0 within the reset cycle, no response emitted. With both requesters valid after release, requester 0 is granted first.
- CNT_W=4, requester 1 only, 17 back-to-back jobs: jobs_done_o counts 1..15, 0, 1. rsp_id_o=1 throughout. Period 13 cycles.
- No requests for 50 cycles after reset: req_ready_o=0, busy_o=0, core_en_o=0, rsp_valid_o=0 throughout.
